// File: rtl/fpmul_wb_buffer_pkg.sv
// Shared FP definitions: exception flag bit positions and datapath widths
// used between the multiplier, the writeback buffer and the fpcsr.
package fpoperations;

  localparam int RAISE_W  = 11;
  localparam int RES_W    = 68;
  localparam int RES_HI_W = 16;

  localparam int csrfpu_inexact   = 0;
  localparam int csrfpu_underflow = 1;
  localparam int csrfpu_overflow  = 2;
  localparam int csrfpu_divzero   = 3;
  localparam int csrfpu_invalid   = 4;
  localparam int csrfpu_denormal  = 5;
  localparam int csrfpu_snan      = 6;
  localparam int csrfpu_qnan      = 7;
  localparam int csrfpu_inf       = 8;
  localparam int csrfpu_zero      = 9;
  localparam int csrfpu_tiny      = 10;

  function automatic logic trap_of(input logic [RAISE_W-1:0] raise,
                                   input logic [RAISE_W-1:0] mask);
    return |(raise & mask);
  endfunction

endpackage

// File: rtl/fpmul_wb_buffer_fifo.sv
// Result FIFO for the multiply writeback buffer: circular storage with
// occupancy count, flush and a combinational head.
module fpwb_fifo
  import fpoperations::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop_req,
  output logic                       vld,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign vld  = (occ_q != '0);
  assign pop  = vld & pop_req & ~flush;
  assign head = mem_q[rd_q];
  assign occ  = occ_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      occ_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = nxt(wr_q);
      end
      if (pop) rd_d = nxt(rd_q);
      if (push && !pop)      occ_d = occ_q + 1'b1;
      else if (!push && pop) occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // Payload storage carries no reset; occupancy alone qualifies it.
  always_ff @(negedge clk) mem_q <= mem_d;

endmodule

// File: rtl/fpmul_wb_buffer.sv
// FP multiply writeback buffer: issues into the multiplier, tracks tags
// through a latency-matched delay line, and queues results for writeback.
module fpmul_wb_buffer
  import fpoperations::*;
#(
  parameter int TAG_W = 9,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_vld,
  input  logic [TAG_W-1:0]    iss_tag,
  output logic                iss_rdy,
  output logic                mul_en,
  input  logic [RES_W-1:0]    mul_res,
  input  logic [RES_HI_W-1:0] mul_res_hi,
  input  logic [RAISE_W-1:0]  mul_raise,
  input  logic [RAISE_W-1:0]  trap_mask,
  input  logic                flush,
  input  logic                sticky_clr,
  output logic [RAISE_W-1:0]  sticky,
  output logic                wb_vld,
  input  logic                wb_rdy,
  output logic [TAG_W-1:0]    wb_tag,
  output logic [RES_W-1:0]    wb_res,
  output logic [RES_HI_W-1:0] wb_res_hi,
  output logic                wb_trap
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int SUM_W = $clog2(DEPTH+LAT+1);
  localparam int EW    = TAG_W + RES_W + RES_HI_W + 1;

  logic [LAT-1:0]            dl_vld_q, dl_vld_d;
  logic [LAT-1:0][TAG_W-1:0] dl_tag_q, dl_tag_d;
  logic [RAISE_W-1:0]        sticky_q, sticky_d;
  logic [SUM_W-1:0]          inflight;
  logic [CNT_W-1:0]          occ;
  logic [EW-1:0]             push_data, head;
  logic                      push;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + SUM_W'(dl_vld_q[i]);
  end

  // Credits cover buffered plus in-flight ops so a landing result always has a slot.
  assign iss_rdy = rst & ((SUM_W'(occ) + inflight) < SUM_W'(DEPTH));
  assign mul_en  = iss_vld & iss_rdy;
  assign push    = dl_vld_q[LAT-1] & ~flush;

  always_comb begin
    dl_vld_d    = '0;
    dl_tag_d    = dl_tag_q;
    dl_vld_d[0] = mul_en & ~flush;
    dl_tag_d[0] = iss_tag;
    for (int i = 1; i < LAT; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1] & ~flush;
      dl_tag_d[i] = dl_tag_q[i-1];
    end
  end

  // A clear coinciding with a push keeps the freshly raised flags.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr)  sticky_d = push ? mul_raise : '0;
    else if (push)   sticky_d = sticky_q | mul_raise;
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      dl_vld_q <= '0;
      dl_tag_q <= '0;
      sticky_q <= '0;
    end else begin
      dl_vld_q <= dl_vld_d;
      dl_tag_q <= dl_tag_d;
      sticky_q <= sticky_d;
    end
  end

  assign sticky    = sticky_q;
  assign push_data = {dl_tag_q[LAT-1], mul_res, mul_res_hi, trap_of(mul_raise, trap_mask)};

  fpwb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop_req   (wb_rdy),
    .vld       (wb_vld),
    .head      (head),
    .occ       (occ)
  );

  assign {wb_tag, wb_res, wb_res_hi, wb_trap} = head;

endmodule

// File: tb/tb_fpmul_wb_buffer.sv
// Directed bench for fpmul_wb_buffer with a behavioural LAT-stage multiplier.
module tb_fpmul_wb_buffer;

  localparam int TAG_W = 9;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_vld;
  logic [8:0]  iss_tag;
  logic        iss_rdy, mul_en;
  logic [67:0] mul_res;
  logic [15:0] mul_res_hi;
  logic [10:0] mul_raise, trap_mask;
  logic        flush, sticky_clr;
  logic [10:0] sticky;
  logic        wb_vld, wb_rdy;
  logic [8:0]  wb_tag;
  logic [67:0] wb_res;
  logic [15:0] wb_res_hi;
  logic        wb_trap;

  logic [67:0] op_res;
  logic [15:0] op_hi;
  logic [10:0] op_raise;

  int checks   = 0;
  int failures = 0;
  int nxt_tag;

  always #5 clk = ~clk;

  fpmul_wb_buffer #(.TAG_W(TAG_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .iss_vld(iss_vld), .iss_tag(iss_tag), .iss_rdy(iss_rdy),
    .mul_en(mul_en), .mul_res(mul_res), .mul_res_hi(mul_res_hi), .mul_raise(mul_raise),
    .trap_mask(trap_mask), .flush(flush), .sticky_clr(sticky_clr), .sticky(sticky),
    .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_tag(wb_tag), .wb_res(wb_res),
    .wb_res_hi(wb_res_hi), .wb_trap(wb_trap)
  );

  // Multiplier model: operands captured on en, result presented in the last stage.
  logic        m_vld   [LAT];
  logic [67:0] m_res   [LAT];
  logic [15:0] m_hi    [LAT];
  logic [10:0] m_raise [LAT];

  always @(negedge clk) begin
    m_vld[0]   <= mul_en;
    m_res[0]   <= op_res;
    m_hi[0]    <= op_hi;
    m_raise[0] <= op_raise;
    for (int i = 1; i < LAT; i++) begin
      m_vld[i]   <= m_vld[i-1];
      m_res[i]   <= m_res[i-1];
      m_hi[i]    <= m_hi[i-1];
      m_raise[i] <= m_raise[i-1];
    end
  end

  // Idle cycles carry junk so that unqualified captures show up.
  assign mul_res    = m_vld[LAT-1] ? m_res[LAT-1]   : '1;
  assign mul_res_hi = m_vld[LAT-1] ? m_hi[LAT-1]    : '1;
  assign mul_raise  = m_vld[LAT-1] ? m_raise[LAT-1] : 11'h7FF;

  always @(negedge clk) begin
    if (rst === 1'b1 && dut.push === 1'b1 && dut.u_fifo.pop === 1'b0) begin
      assert (dut.u_fifo.occ_q !== 3'(DEPTH)) else begin
        failures++;
        $error("FAIL fifo_overflow observed occ=%0d with push and no pop", dut.u_fifo.occ_q);
      end
    end
  end

  `define CHK(tag, obs, exp) \
    checks++; \
    assert ((obs) === (exp)) else begin \
      failures++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [8:0] t, input logic [10:0] r);
    iss_tag  = t;
    op_res   = 68'h0_1000_0000_0000_0000 | 68'(t);
    op_hi    = 16'hA000 | 16'(t);
    op_raise = r;
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) m_vld[i] = 1'b0;
    rst = 1'b0; iss_vld = 1'b0; flush = 1'b0; sticky_clr = 1'b0;
    wb_rdy = 1'b0; trap_mask = '0;
    set_op(9'h0, 11'h0);

    // reset
    tick(); tick();
    `CHK("rst_wb_vld", wb_vld, 1'b0)
    `CHK("rst_sticky", sticky, 11'h000)
    `CHK("rst_occ", dut.u_fifo.occ_q, 3'd0)
    iss_vld = 1'b1; #1;
    `CHK("rst_iss_rdy", iss_rdy, 1'b0)
    `CHK("rst_mul_en", mul_en, 1'b0)
    tick();
    rst = 1'b1; iss_vld = 1'b0;
    tick();

    // single op latency and data
    wb_rdy = 1'b1;
    set_op(9'h05, 11'h0);
    op_res = 68'h0_3FF0_0000_0000_0000;
    iss_vld = 1'b1; #1;
    `CHK("single_iss_rdy", iss_rdy, 1'b1)
    `CHK("single_mul_en", mul_en, 1'b1)
    tick();
    iss_vld = 1'b0;
    `CHK("single_wait1", wb_vld, 1'b0)
    tick();
    `CHK("single_wait2", wb_vld, 1'b0)
    tick();
    `CHK("single_wait3", wb_vld, 1'b0)
    tick();
    `CHK("single_wb_vld", wb_vld, 1'b1)
    `CHK("single_wb_tag", wb_tag, 9'h05)
    `CHK("single_wb_res", wb_res, 68'h0_3FF0_0000_0000_0000)
    `CHK("single_wb_hi", wb_res_hi, 16'hA005)
    tick();
    `CHK("single_drained", wb_vld, 1'b0)
    `CHK("single_occ0", dut.u_fifo.occ_q, 3'd0)

    // back-pressure: only DEPTH credits
    wb_rdy = 1'b0; iss_vld = 1'b1; nxt_tag = 1;
    repeat (8) begin
      set_op(9'(nxt_tag), 11'h0); #1;
      if (mul_en) nxt_tag++;
      tick();
    end
    `CHK("bp_accepted", nxt_tag, 5)
    `CHK("bp_occ_full", dut.u_fifo.occ_q, 3'd4)
    set_op(9'd5, 11'h0); wb_rdy = 1'b1; #1;
    `CHK("bp_no_credit", iss_rdy, 1'b0)
    `CHK("bp_head1", wb_tag, 9'd1)
    tick();
    `CHK("bp_head2", wb_tag, 9'd2)
    `CHK("bp_credit_back", iss_rdy, 1'b1)
    tick();
    set_op(9'd6, 11'h0); #1;
    `CHK("bp_head3", wb_tag, 9'd3)
    `CHK("bp_issue6", mul_en, 1'b1)
    tick();
    iss_vld = 1'b0;
    `CHK("bp_head4", wb_tag, 9'd4)
    tick();
    `CHK("bp_gap", wb_vld, 1'b0)
    tick();
    `CHK("bp_head5", wb_tag, 9'd5)
    `CHK("bp_res5", wb_res, 68'h0_1000_0000_0000_0005)
    tick();
    `CHK("bp_head6", wb_tag, 9'd6)
    tick();
    `CHK("bp_empty", wb_vld, 1'b0)

    // simultaneous push and pop with three buffered
    wb_rdy = 1'b0; iss_vld = 1'b1;
    for (int t = 9'h11; t <= 9'h14; t++) begin
      set_op(9'(t), 11'h0);
      tick();
    end
    iss_vld = 1'b0;
    tick(); tick();
    `CHK("pp_occ3", dut.u_fifo.occ_q, 3'd3)
    `CHK("pp_head11", wb_tag, 9'h11)
    `CHK("pp_no_credit", iss_rdy, 1'b0)
    wb_rdy = 1'b1;
    tick();
    `CHK("pp_occ_hold", dut.u_fifo.occ_q, 3'd3)
    `CHK("pp_head12", wb_tag, 9'h12)
    tick();
    `CHK("pp_head13", wb_tag, 9'h13)
    tick();
    `CHK("pp_head14", wb_tag, 9'h14)
    `CHK("pp_res14", wb_res, 68'h0_1000_0000_0000_0014)
    tick();
    `CHK("pp_empty", wb_vld, 1'b0)

    // sticky accumulation and clear
    `CHK("st_idle_ignored", sticky, 11'h000)
    iss_vld = 1'b1;
    set_op(9'h61, 11'h004); tick();
    set_op(9'h62, 11'h010); tick();
    set_op(9'h63, 11'h001); tick();
    iss_vld = 1'b0;
    tick();
    `CHK("st_a", sticky, 11'h004)
    tick();
    `CHK("st_ab", sticky, 11'h014)
    sticky_clr = 1'b1;
    tick();
    `CHK("st_clr_push", sticky, 11'h001)
    tick();
    `CHK("st_clr_only", sticky, 11'h000)
    sticky_clr = 1'b0;

    // trap computation
    wb_rdy = 1'b0; trap_mask = 11'h010;
    set_op(9'h21, 11'h010); iss_vld = 1'b1; tick();
    iss_vld = 1'b0; tick(); tick(); tick();
    `CHK("trap_vld", wb_vld, 1'b1)
    `CHK("trap_set", wb_trap, 1'b1)
    `CHK("trap_sticky", sticky, 11'h010)
    wb_rdy = 1'b1; sticky_clr = 1'b1;
    tick();
    `CHK("trap_clr", sticky, 11'h000)
    sticky_clr = 1'b0; wb_rdy = 1'b0; trap_mask = 11'h000;
    set_op(9'h22, 11'h010); iss_vld = 1'b1; tick();
    iss_vld = 1'b0; tick(); tick(); tick();
    `CHK("notrap_tag", wb_tag, 9'h22)
    `CHK("notrap_clear", wb_trap, 1'b0)
    `CHK("notrap_sticky", sticky, 11'h010)
    wb_rdy = 1'b1; tick();
    wb_rdy = 1'b0;

    // flush with two buffered and two in flight
    iss_vld = 1'b1;
    set_op(9'h31, 11'h100); tick();
    set_op(9'h32, 11'h100); tick();
    set_op(9'h33, 11'h200); tick();
    set_op(9'h34, 11'h200); tick();
    iss_vld = 1'b0;
    tick();
    `CHK("fl_occ2", dut.u_fifo.occ_q, 3'd2)
    `CHK("fl_sticky_pre", sticky, 11'h110)
    flush = 1'b1;
    tick();
    flush = 1'b0;
    `CHK("fl_wb_vld", wb_vld, 1'b0)
    `CHK("fl_occ0", dut.u_fifo.occ_q, 3'd0)
    `CHK("fl_sticky_kept", sticky, 11'h110)
    tick();
    `CHK("fl_late1", wb_vld, 1'b0)
    `CHK("fl_late_sticky", sticky, 11'h110)
    tick();
    `CHK("fl_late2", wb_vld, 1'b0)
    `CHK("fl_rdy_back", iss_rdy, 1'b1)
    set_op(9'h50, 11'h020); iss_vld = 1'b1; flush = 1'b1; #1;
    `CHK("fl_kill_accept", mul_en, 1'b1)
    tick();
    iss_vld = 1'b0; flush = 1'b0;
    tick(); tick(); tick();
    `CHK("fl_kill_nopush", wb_vld, 1'b0)
    `CHK("fl_kill_sticky", sticky, 11'h110)

    // reset mid-stream
    iss_vld = 1'b1;
    set_op(9'h41, 11'h040); tick();
    set_op(9'h42, 11'h040); tick();
    iss_vld = 1'b0;
    tick(); tick();
    `CHK("mr_vld_pre", wb_vld, 1'b1)
    `CHK("mr_sticky_pre", sticky, 11'h150)
    rst = 1'b0; iss_vld = 1'b1; #1;
    `CHK("mr_iss_rdy", iss_rdy, 1'b0)
    `CHK("mr_mul_en", mul_en, 1'b0)
    tick();
    `CHK("mr_sticky0", sticky, 11'h000)
    `CHK("mr_wb_vld0", wb_vld, 1'b0)
    `CHK("mr_iss_rdy_hold", iss_rdy, 1'b0)
    rst = 1'b1; iss_vld = 1'b0;
    tick(); tick();
    `CHK("mr_post_vld", wb_vld, 1'b0)
    `CHK("mr_post_sticky", sticky, 11'h000)

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpmul_wb_buffer.md
Name: fpmul_wb_buffer

Overview:
- Downstream companion of the FP multiply pipeline. Sits between that pipeline and the FP register-file writeback port.
- Issues operations into the multiplier and tracks them with a tag delay line matched to the multiplier latency.
- Captures the result, high exponent/sign word and raise flags into a small FIFO, then presents them on a ready/valid writeback port.
- Accumulates sticky exception flags and issues back-pressure through credits, so no result is ever dropped.

Parameters:
- TAG_W, 9, width of the destination-register tag.
- LAT, 3, multiplier latency in clk edges from sampled en to valid res/res_hi/raise.
- DEPTH, 4, FIFO entries; must be >= 1.

Ports:
- clk  in  1  clock; all registers update on the falling edge, like the multiplier.
- rst  in  1  reset, synchronous, active-low.
- iss_vld  in  1  upstream has a multiply to issue.
- iss_tag  in  TAG_W  destination tag of the issuing op.
- iss_rdy  out  1  block can accept an issue this cycle.
- mul_en  out  1  drives multiplier en; equals iss_vld & iss_rdy.
- mul_res  in  68  multiplier res.
- mul_res_hi  in  16  multiplier res_hi.
- mul_raise  in  11  multiplier raise flags, indexed by csrfpu_* bit positions.
- trap_mask  in  11  fpcsr exception-enable bits.
- flush  in  1  kill all in-flight and buffered ops.
- sticky_clr  in  1  clear sticky flags.
- sticky  out  11  accumulated raise flags.
- wb_vld  out  1  FIFO head valid.
- wb_rdy  in  1  writeback consumes the head.
- wb_tag  out  TAG_W  head tag.
- wb_res  out  68  head result.
- wb_res_hi  out  16  head high word.
- wb_trap  out  1  head raised an enabled exception.

Behaviour:
- Reset (rst=0 at an edge):
  - Clears the delay line, FIFO pointers, occupancy, in-flight count and sticky.
  - While rst=0, iss_rdy=0 and mul_en=0. wb_vld=0 and sticky=0 from the first reset edge.
  - Reset mid-operation discards everything.
- Issue:
  - Accept = iss_vld & iss_rdy.
  - iss_rdy = rst & (occ + inflight < DEPTH). The count is conservative: a same-cycle pop is not credited.
- Delay line:
  - LAT stages of {valid, tag}. Stage 0 loads {accept, iss_tag}; each stage shifts every edge.
  - inflight = number of valid stages, range 0..LAT.
- Push:
  - On the edge where stage LAT-1 is valid, the block writes one entry to the FIFO tail: {tag, mul_res, mul_res_hi, trap = |(mul_raise & trap_mask)}.
  - On that same edge, sticky <= sticky | mul_raise. Raise is ignored on non-push cycles.
- Pop: on wb_vld & wb_rdy, the head advances. wb_vld = (occ != 0); the wb_* outputs come directly from the head entry.
- Counters:
  - occ is 0..DEPTH. Simultaneous push+pop leaves occ unchanged, including at full and at empty+1.
  - Pointers wrap modulo DEPTH.
  - A push with occ==DEPTH and no pop is impossible by construction; the bench asserts it.
- sticky_clr:
  - sticky_clr with no push sets sticky to 0.
  - sticky_clr on the same edge as a push sets sticky to mul_raise; new flags win.
- Flush:
  - Clears delay-line valids, occ and the pointers on that edge. A pop on the same edge is ignored.
  - A result landing on the flush edge is discarded.
  - sticky is kept.
  - iss_rdy stays as computed from the pre-flush counts during the flush cycle; any issue accepted on the flush edge is also killed.
- Latency:
  - An op accepted at edge N is pushed at edge N+LAT; wb_vld is high after that edge.
  - Minimum issue-to-wb_vld is LAT+1 edges.

Decomposition:
- Shared package (fpoperations): csrfpu_* bit indices and RAISE_W=11.
- Sub-module fpwb_fifo(DEPTH, width TAG_W+68+16+1): holds the pointers, occ, push/pop/flush and the head outputs.
- The top level holds the delay line, credit logic, sticky logic and trap computation.

Test Plan:
- Single op: issue tag 0x05 with wb_rdy=1 and the multiplier model returning res=0x0_3FF0000000000000 → wb_vld rises LAT+1 edges after issue, wb_tag=0x05, wb_res matches, occ returns to 0.
- Back-pressure: wb_rdy=0 with iss_vld held, tags 1..6 offered → exactly 4 accepted, iss_rdy=0 after the 4th. Then wb_rdy=1 → tags 1,2,3,4 pop in order, and issues resume once credits free.
- Full push+pop: with occ=3 and one op in flight, assert wb_rdy on the edge its result lands → occ stays 3, no assertion fires, ordering is preserved.
- Sticky: op A raise=0x004, op B raise=0x010, then sticky_clr on the same edge as op C with raise=0x001 → sticky reads 0x004, then 0x014, then 0x001.
- Trap: trap_mask=0x010, raise=0x010 → wb_trap=1. Same raise with trap_mask=0 → wb_trap=0, while sticky still gains 0x010.
- Flush and reset: flush with 2 ops in flight and 2 buffered → wb_vld=0 next cycle, later result cycles push nothing, sticky unchanged. Pulling rst low mid-stream → sticky=0 and iss_rdy=0 while rst is low.
